// File: rtl/systolic_tile_sequencer.sv
// Tile-operation sequencer for the OS/WS systolic array: command latch, operand streaming, flush wait, drain and result handshake.
// Optional build macro SEQ_PERF_CNT_EN adds the perf_cycles / perf_stalls counters.
module systolic_tile_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int K_WIDTH    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       mode,
  input  logic [K_WIDTH-1:0]         k_len,
  output logic                       busy,
  output logic                       done,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH*ROWS-1:0] in_a,
  input  logic [DATA_WIDTH*COLS-1:0] in_b,
  output logic                       sa_enable,
  output logic                       sa_load,
  output logic                       sa_data_flow,
  output logic                       sa_drain,
  output logic [DATA_WIDTH*ROWS-1:0] sa_A,
  output logic [DATA_WIDTH*COLS-1:0] sa_B,
  output logic                       res_valid,
  input  logic                       res_ready
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]                perf_cycles,
  output logic [31:0]                perf_stalls
`endif
);

  localparam int FLUSH_W = $clog2(ROWS + COLS) + 1;
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(ROWS + COLS - 2);
  localparam logic [K_WIDTH-1:0] LOAD_LAST  = K_WIDTH'(ROWS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STREAM = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_RESP   = 3'd5
  } state_t;

  state_t                       state_r;
  logic [K_WIDTH-1:0]           k_len_r;
  logic [K_WIDTH-1:0]           beat_cnt_r;
  logic [FLUSH_W-1:0]           flush_cnt_r;
  logic                         sa_enable_r;
  logic                         sa_load_r;
  logic                         sa_data_flow_r;
  logic [DATA_WIDTH*ROWS-1:0]   sa_a_r;
  logic [DATA_WIDTH*COLS-1:0]   sa_b_r;
  logic                         res_valid_r;

  logic                         in_ready_s;
  logic                         accept_s;
  logic                         last_beat_s;
  logic                         cmd_accept_s;
  logic [K_WIDTH-1:0]           beat_last_s;

  // Handshake decode: beat acceptance, last-beat detection and command acceptance
  always_comb begin
    in_ready_s   = 1'b0;
    beat_last_s  = LOAD_LAST;
    case (state_r)
      ST_LOAD: begin
        in_ready_s  = 1'b1;
        beat_last_s = LOAD_LAST;
      end
      ST_STREAM: begin
        in_ready_s  = 1'b1;
        beat_last_s = k_len_r - {{(K_WIDTH-1){1'b0}}, 1'b1};
      end
      default: begin
        in_ready_s  = 1'b0;
        beat_last_s = LOAD_LAST;
      end
    endcase
    accept_s     = in_valid & in_ready_s;
    last_beat_s  = accept_s & (beat_cnt_r == beat_last_s);
    cmd_accept_s = (state_r == ST_IDLE) & start & (k_len != {K_WIDTH{1'b0}});
  end

  // Main sequencing FSM with registered array-side outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      k_len_r        <= {K_WIDTH{1'b0}};
      beat_cnt_r     <= {K_WIDTH{1'b0}};
      flush_cnt_r    <= {FLUSH_W{1'b0}};
      sa_enable_r    <= 1'b0;
      sa_load_r      <= 1'b0;
      sa_data_flow_r <= 1'b0;
      sa_a_r         <= '0;
      sa_b_r         <= '0;
      res_valid_r    <= 1'b0;
    end else begin
      // array pins idle unless a beat is accepted this cycle
      sa_enable_r <= 1'b0;
      sa_load_r   <= 1'b0;
      sa_a_r      <= '0;
      sa_b_r      <= '0;
      case (state_r)
        ST_IDLE: begin
          if (cmd_accept_s) begin
            k_len_r        <= k_len;
            sa_data_flow_r <= mode;
            beat_cnt_r     <= {K_WIDTH{1'b0}};
            state_r        <= mode ? ST_LOAD : ST_STREAM;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (accept_s) begin
            sa_load_r <= 1'b1;
            sa_b_r    <= in_b;
            if (last_beat_s) begin
              beat_cnt_r <= {K_WIDTH{1'b0}};
              state_r    <= ST_STREAM;
            end else begin
              beat_cnt_r <= beat_cnt_r + {{(K_WIDTH-1){1'b0}}, 1'b1};
            end
          end else begin
            state_r <= ST_LOAD;
          end
        end
        ST_STREAM: begin
          if (accept_s) begin
            sa_enable_r <= 1'b1;
            sa_a_r      <= in_a;
            sa_b_r      <= in_b;
            if (last_beat_s) begin
              flush_cnt_r <= {FLUSH_W{1'b0}};
              state_r     <= ST_FLUSH;
            end else begin
              beat_cnt_r <= beat_cnt_r + {{(K_WIDTH-1){1'b0}}, 1'b1};
            end
          end else begin
            state_r <= ST_STREAM;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_r == FLUSH_LAST) begin
            state_r <= ST_DRAIN;
          end else begin
            flush_cnt_r <= flush_cnt_r + {{(FLUSH_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DRAIN: begin
          res_valid_r <= 1'b1;
          state_r     <= ST_RESP;
        end
        ST_RESP: begin
          if (res_ready) begin
            res_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_RESP;
          end
        end
        default: begin
          res_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy         = (state_r != ST_IDLE);
  assign sa_drain     = (state_r == ST_DRAIN);
  assign in_ready     = in_ready_s;
  assign done         = res_valid_r & res_ready;
  assign sa_enable    = sa_enable_r;
  assign sa_load      = sa_load_r;
  assign sa_data_flow = sa_data_flow_r;
  assign sa_A         = sa_a_r;
  assign sa_B         = sa_b_r;
  assign res_valid    = res_valid_r;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] perf_cycles_r;
  logic [31:0] stall_cnt_r;

  // Busy-cycle counter: restarts with each command, saturates, holds in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles_r <= 32'd0;
    end else if (cmd_accept_s) begin
      perf_cycles_r <= 32'd0;
    end else if (busy && (perf_cycles_r != 32'hFFFF_FFFF)) begin
      perf_cycles_r <= perf_cycles_r + 32'd1;
    end else begin
      perf_cycles_r <= perf_cycles_r;
    end
  end

  // Operand starvation counter: beat slots offered with no valid data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= 32'd0;
    end else if (in_ready_s && !in_valid && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign perf_cycles = perf_cycles_r;
  assign perf_stalls = stall_cnt_r;
`endif

endmodule
